// File: rtl/adc_pkg.sv
// rtl/adc_pkg.sv - shared types and UART constants for the ADC streamer
package adc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_e;

    localparam int CLKS_PER_BIT_DEFAULT = 434;
    localparam int FRAME_BITS           = 10;
    localparam int DATA_BITS            = FRAME_BITS - 2;

endpackage

// File: rtl/uart_tx_8n1.sv
// rtl/uart_tx_8n1.sv - 8N1 UART serializer with valid/ready byte load
module uart_tx_8n1
    import adc_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       load_valid,
    input  logic [7:0] load_data,
    output logic       load_ready,
    output logic       tx,
    output logic       busy
);

    localparam int                BAUD_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]        BIT_LAST  = 3'(DATA_BITS - 1);

    tx_state_e         state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [2:0]        bit_q, bit_d;
    logic [7:0]        shift_q, shift_d;
    logic              tx_q, tx_d;
    logic              busy_q, busy_d;
    logic              baud_end;

    assign baud_end   = (baud_q == BAUD_LAST);
    // A byte can be taken when idle, or on the last stop-bit cycle so frames abut
    assign load_ready = (state_q == IDLE) || ((state_q == STOP) && baud_end);
    assign tx         = tx_q;
    assign busy       = busy_q;

    // Next-state, baud/bit counting and shifting; tx/busy derived from the next state
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        case (state_q)
            IDLE: begin
                baud_d = '0;
                if (load_valid) begin
                    shift_d = load_data;
                    state_d = START;
                end
            end
            START: begin
                if (baud_end) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = DATA;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            DATA: begin
                if (baud_end) begin
                    baud_d = '0;
                    if (bit_q == BIT_LAST) begin
                        state_d = STOP;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shift_d = {1'b0, shift_q[7:1]};
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            STOP: begin
                if (baud_end) begin
                    baud_d = '0;
                    if (load_valid) begin
                        shift_d = load_data;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
        busy_d = (state_d != IDLE);
    end

    // Serializer registers; reset aborts any frame and parks the line high
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
        end
    end

endmodule

// File: rtl/adc_uart_streamer.sv
// rtl/adc_uart_streamer.sv - buffers ADC samples in a FIFO and streams them over UART
module adc_uart_streamer
    import adc_pkg::*;
#(
    parameter int ADC_WIDTH       = 8,
    parameter int FIFO_DEPTH_BITS = 4,
    parameter int CLKS_PER_BIT    = CLKS_PER_BIT_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     sample_rdy,
    input  logic [ADC_WIDTH-1:0]     sample_data,
    input  logic                     clr_overflow,
    output logic                     tx,
    output logic                     busy,
    output logic                     overflow,
    output logic [FIFO_DEPTH_BITS:0] fifo_level
);

    localparam int DEPTH = 2 ** FIFO_DEPTH_BITS;

    logic [7:0]               mem [DEPTH];
    logic [FIFO_DEPTH_BITS:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_DEPTH_BITS:0] rd_ptr_q, rd_ptr_d;
    logic [FIFO_DEPTH_BITS:0] level;
    logic                     overflow_q, overflow_d;
    logic                     empty, full, pop, push, drop;
    logic                     load_ready;
    logic [7:0]               sample_ext;
    logic [7:0]               head;

    assign sample_ext = 8'(sample_data);
    // Pointers carry one extra MSB, so the difference spans 0..DEPTH
    assign level      = wr_ptr_q - rd_ptr_q;
    assign empty      = (level == '0);
    assign full       = level[FIFO_DEPTH_BITS];
    assign pop        = !empty && load_ready;
    // A simultaneous pop frees the slot being written, so a full FIFO still accepts
    assign push       = sample_rdy && (!full || pop);
    assign drop       = sample_rdy && full && !pop;
    assign head       = mem[rd_ptr_q[FIFO_DEPTH_BITS-1:0]];

    assign fifo_level = level;
    assign overflow   = overflow_q;

    // Pointer advance and sticky overflow; a new drop beats a clear
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        overflow_d = overflow_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (drop) begin
            overflow_d = 1'b1;
        end else if (clr_overflow) begin
            overflow_d = 1'b0;
        end
    end

    // Control registers; reset empties the FIFO without touching its storage
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            overflow_q <= overflow_d;
        end
    end

    // Sample storage, written only on an accepted push
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q[FIFO_DEPTH_BITS-1:0]] <= sample_ext;
        end
    end

    uart_tx_8n1 #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_uart_tx (
        .clk        (clk),
        .rstn       (rstn),
        .load_valid (!empty),
        .load_data  (head),
        .load_ready (load_ready),
        .tx         (tx),
        .busy       (busy)
    );

endmodule

// File: tb/tb_adc_uart_streamer.sv
// tb/tb_adc_uart_streamer.sv - scoreboard bench for adc_uart_streamer
module tb_adc_uart_streamer;

    localparam int CPB = 4;
    localparam int FDB = 2;

    logic         clk          = 1'b0;
    logic         rstn         = 1'b1;
    logic         sample_rdy   = 1'b0;
    logic [7:0]   sample_data  = 8'h00;
    logic         clr_overflow = 1'b0;
    logic         tx;
    logic         busy;
    logic         overflow;
    logic [FDB:0] fifo_level;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         cyc      = 0;
    logic [7:0] exp_q [$];
    int         busy_cnt;
    int         max_level;
    int         s1, s2;
    int         st [6];
    logic [7:0] ov_data [6];

    adc_uart_streamer #(
        .ADC_WIDTH       (8),
        .FIFO_DEPTH_BITS (FDB),
        .CLKS_PER_BIT    (CPB)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .sample_rdy   (sample_rdy),
        .sample_data  (sample_data),
        .clr_overflow (clr_overflow),
        .tx           (tx),
        .busy         (busy),
        .overflow     (overflow),
        .fifo_level   (fifo_level)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic recv_frame(output int start_cyc);
        int         n;
        logic [7:0] b;
        logic [7:0] e;
        n         = 0;
        b         = 8'h00;
        start_cyc = 0;
        @(negedge clk);
        while (tx !== 1'b0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) begin
            check("rx_timeout", 1, 0);
        end else begin
            start_cyc = cyc;
            repeat (2) @(negedge clk);
            check("rx_start", tx, 0);
            for (int i = 0; i < 8; i++) begin
                repeat (CPB) @(negedge clk);
                b[i] = tx;
            end
            repeat (CPB) @(negedge clk);
            check("rx_stop", tx, 1);
            check("rx_busy", busy, 1);
            @(negedge clk);
            if (exp_q.size() == 0) begin
                check("rx_unexpected", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("rx_byte", b, e);
            end
        end
    endtask

    task automatic push_lat(input logic [7:0] d);
        @(negedge clk);
        sample_rdy  = 1'b1;
        sample_data = d;
        @(negedge clk);
        sample_rdy = 1'b0;
        check("lat_n_tx", tx, 1);
        check("lat_n_level", fifo_level, 1);
        @(negedge clk);
        check("lat_n1_tx", tx, 0);
        check("lat_n1_busy", busy, 1);
        check("lat_n1_level", fifo_level, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        ov_data = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};

        #2 rstn = 1'b0;
        #1;
        check("rst_tx", tx, 1);
        check("rst_busy", busy, 0);
        check("rst_overflow", overflow, 0);
        check("rst_level", fifo_level, 0);
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        repeat (2) @(negedge clk);

        exp_q.push_back(8'hA5);
        busy_cnt = 0;
        fork
            push_lat(8'hA5);
            recv_frame(s1);
            begin
                repeat (60) begin
                    @(negedge clk);
                    if (busy) busy_cnt++;
                end
            end
        join
        check("single_busy_cycles", busy_cnt, 40);
        repeat (3) @(negedge clk);

        exp_q.push_back(8'h01);
        exp_q.push_back(8'h80);
        max_level = 0;
        fork
            begin
                @(negedge clk);
                sample_rdy  = 1'b1;
                sample_data = 8'h01;
                @(negedge clk);
                sample_data = 8'h80;
                @(negedge clk);
                sample_rdy = 1'b0;
                check("b2b_level", fifo_level, 1);
                check("b2b_busy", busy, 1);
            end
            begin
                recv_frame(s1);
                recv_frame(s2);
                check("b2b_gap", s2 - s1, 40);
            end
            begin
                repeat (20) begin
                    @(negedge clk);
                    if (int'(fifo_level) > max_level) max_level = int'(fifo_level);
                end
            end
        join
        check("b2b_max_level", max_level, 1);
        repeat (3) @(negedge clk);

        for (int i = 0; i < 5; i++) exp_q.push_back(ov_data[i]);
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    @(negedge clk);
                    sample_rdy  = 1'b1;
                    sample_data = ov_data[i];
                end
                @(negedge clk);
                sample_rdy = 1'b0;
                check("ovf_set", overflow, 1);
                check("ovf_level", fifo_level, 4);
                @(negedge clk);
                clr_overflow = 1'b1;
                @(negedge clk);
                clr_overflow = 1'b0;
                check("ovf_clear", overflow, 0);
                check("ovf_clear_level", fifo_level, 4);
                repeat (33) @(negedge clk);
                sample_rdy  = 1'b1;
                sample_data = 8'h77;
                exp_q.push_back(8'h77);
                @(negedge clk);
                sample_rdy = 1'b0;
                check("full_pop_push_ovf", overflow, 0);
                check("full_pop_push_level", fifo_level, 4);
                @(negedge clk);
                sample_rdy   = 1'b1;
                sample_data  = 8'hEE;
                clr_overflow = 1'b1;
                @(negedge clk);
                sample_rdy   = 1'b0;
                clr_overflow = 1'b0;
                check("prio_drop_wins", overflow, 1);
                check("prio_level", fifo_level, 4);
                @(negedge clk);
                clr_overflow = 1'b1;
                @(negedge clk);
                clr_overflow = 1'b0;
                check("prio_clear_alone", overflow, 0);
            end
            begin
                for (int i = 0; i < 6; i++) recv_frame(st[i]);
                for (int i = 1; i < 6; i++) check("ovf_frame_gap", st[i] - st[i-1], 40);
            end
        join
        repeat (3) @(negedge clk);

        @(negedge clk);
        sample_rdy  = 1'b1;
        sample_data = 8'h52;
        @(negedge clk);
        sample_rdy = 1'b0;
        @(negedge clk);
        sample_rdy  = 1'b1;
        sample_data = 8'hC3;
        @(negedge clk);
        sample_rdy = 1'b0;
        repeat (16) @(negedge clk);
        check("pre_rst_busy", busy, 1);
        check("pre_rst_level", fifo_level, 1);
        check("pre_rst_bit3", tx, 0);
        rstn = 1'b0;
        #1;
        check("mid_rst_tx", tx, 1);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_level", fifo_level, 0);
        check("mid_rst_overflow", overflow, 0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        check("post_rst_idle_tx", tx, 1);
        exp_q.push_back(8'h3C);
        fork
            push_lat(8'h3C);
            recv_frame(s1);
        join
        repeat (3) @(negedge clk);
        check("post_rst_idle_busy", busy, 0);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/adc_uart_streamer.md
ADC_UART_STREAMER -- requirements
Module: adc_uart_streamer

Interface
REQ-001 SHALL have parameter ADC_WIDTH, default 8: width of the sample word; legal range 1..8.
REQ-002 SHALL have parameter FIFO_DEPTH_BITS, default 4: FIFO holds 2^FIFO_DEPTH_BITS samples.
REQ-003 SHALL have parameter CLKS_PER_BIT, default 434: clk cycles per UART bit; minimum 2.
REQ-004 SHALL have port clk, input, 1 bit: sample-rate clock, rising edge.
REQ-005 SHALL have port rstn, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have port sample_rdy, input, 1 bit: single-cycle strobe; sample_data is valid in that cycle.
REQ-007 SHALL have port sample_data, input, ADC_WIDTH bits: decimated ADC output word.
REQ-008 SHALL have port clr_overflow, input, 1 bit: synchronous clear of overflow.
REQ-009 SHALL have port tx, output, 1 bit: UART serial line, 8N1, idle high.
REQ-010 SHALL have port busy, output, 1 bit: high while a frame is on the line.
REQ-011 SHALL have port overflow, output, 1 bit: sticky flag for a dropped sample.
REQ-012 SHALL have port fifo_level, output, FIFO_DEPTH_BITS+1 bits: current occupancy, 0..2^FIFO_DEPTH_BITS.

Function
REQ-013 SHALL push sample_data into the FIFO on the clk edge at which sample_rdy is sampled high, provided the FIFO is not full.
REQ-014 SHALL zero-extend sample_data to 8 bits when ADC_WIDTH<8.
REQ-015 SHALL drop the sample and set overflow on the same edge when a push is requested while the FIFO is full and no pop occurs in that cycle.
REQ-016 SHALL complete both operations when a push and a pop occur in the same cycle while the FIFO is full: no overflow, level unchanged.
REQ-017 SHALL keep overflow set once set; clr_overflow clears it; a new overflow event in the same cycle as clr_overflow SHALL win and leave overflow set.
REQ-018 SHALL use a transmit FSM with states IDLE, START, DATA, STOP.
- IDLE: tx=1.
- IDLE with FIFO non-empty: pop the head entry into the shift register and move to START.
REQ-019 SHALL hold each of START (tx=0), each DATA bit (LSB first, 8 bits) and STOP (tx=1) for exactly CLKS_PER_BIT cycles.
REQ-020 SHALL, at the end of STOP, pop the next entry and go directly to START when the FIFO is non-empty, otherwise go to IDLE; back-to-back frames SHALL have no idle gap.
REQ-021 SHALL make a frame 10*CLKS_PER_BIT cycles long.
REQ-022 SHALL drive tx low starting 2 clk cycles after the sample_rdy edge, given an empty FIFO and IDLE state: push at edge N, pop at edge N+1, tx=0 from edge N+1.
REQ-023 SHALL assert busy in START, DATA and STOP, and deassert it in IDLE.
REQ-024 SHALL update fifo_level on the same edge as the push or pop that changes it.
REQ-025 SHALL register tx glitch-free, with no combinational path from inputs to tx.
REQ-026 SHALL wrap the FIFO read/write pointers modulo 2^FIFO_DEPTH_BITS, using an extra MSB to distinguish full from empty.

Reset
REQ-027 SHALL, while rstn=0, asynchronously force tx=1, busy=0, overflow=0, fifo_level=0, FSM=IDLE, pointers=0, baud counter=0.
REQ-028 SHALL, on reset mid-frame, abort the frame immediately (tx high) and discard FIFO contents; the first sample_rdy after release SHALL start a fresh frame per REQ-022.
REQ-029 SHALL not reset FIFO storage RAM contents (only pointers are reset).

Structure
REQ-030 SHALL place the FSM state enum (IDLE/START/DATA/STOP) and the default UART constants (CLKS_PER_BIT default, frame bit count 10) in shared package adc_pkg.
REQ-031 SHALL implement the serializer (FSM, baud counter, bit counter, shift register) as sub-module uart_tx_8n1 with a valid/ready load handshake; the FIFO SHALL stay in the top module.

Verification (bench uses CLKS_PER_BIT=4, FIFO_DEPTH_BITS=2)
REQ-032 SHALL cover single sample: sample 0xA5 into an idle block -> tx low 2 cycles later, bits 1,0,1,0,0,1,0,1 each 4 cycles, stop high, busy high for 40 cycles.
REQ-033 SHALL cover back-to-back: samples 0x01 then 0x80 one cycle apart -> two contiguous 40-cycle frames, no idle gap, fifo_level peaks at 1.
REQ-034 SHALL cover overflow: 6 samples on consecutive cycles into an idle block -> first popped, 4 buffered, 6th dropped, overflow=1, fifo_level=4; all 5 surviving frames transmitted in order.
REQ-035 SHALL cover the full boundary: push coinciding with the STOP-end pop at fifo_level=4 -> no overflow, level stays 4.
REQ-036 SHALL cover overflow priority: clr_overflow asserted in the same cycle as a drop -> overflow remains 1; clr_overflow alone next cycle -> overflow 0.
REQ-037 SHALL cover reset mid-frame: rstn low during DATA bit 3 -> tx=1, busy=0, fifo_level=0 without a clock; after release, sample 0x3C -> correct frame.
